// File: rtl/multi_segment_clockgen.sv
`default_nettype none
// ============================================================================
// Module      : multi_segment_clockgen
// Description : Plays a stream of segment words as gated clock patterns.
//               A GEN segment drives on_counts high / off_counts low cycles,
//               repeated repeat_counts times, on the channels in ch_mask.
//               A segment with repeat_counts==0 is a WAIT: outputs idle
//               until a retrig_in rising edge or an on_counts-cycle timeout
//               (0 = no timeout). The next word is taken in the last cycle
//               of a segment, so back-to-back segments have no gap.
// Ports       : refclk, reset (sync, active-high)
//               start / abort            - single-cycle control pulses
//               retrig_in                - retrigger level (refclk domain)
//               seg_data/valid/ready     - FWFT segment source handshake
//               clk_out[NCH]             - generated clocks (registered)
//               busy, done, aborted      - run status (done/aborted sticky)
//               samples_generated, wait_samples, retrig_timeouts,
//               segs_accepted            - per-run statistics
// Revision    : 1.0 - initial release
// ============================================================================
module multi_segment_clockgen #(
  parameter int CW  = 48,
  parameter int RW  = 32,
  parameter int NCH = 4,
  parameter logic [NCH-1:0] INVERT = {NCH{1'b0}}
) (
  input  logic                    refclk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    retrig_in,
  input  logic [2*CW+RW+NCH-1:0]  seg_data,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  output logic [NCH-1:0]          clk_out,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [31:0]             samples_generated,
  output logic [31:0]             wait_samples,
  output logic [15:0]             retrig_timeouts,
  output logic [15:0]             segs_accepted
);

  localparam logic [CW:0]   PONE = 1;
  localparam logic [RW-1:0] RONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  on_cfg, on_n, off_cfg, off_n;
  logic [RW-1:0]  rep_cfg, rep_cfg_n, rep_cnt, rep_cnt_n;
  logic [NCH-1:0] mask, mask_n;
  // Position within the current period in GEN; elapsed cycles in WAIT.
  logic [CW:0]    pos, pos_n;
  logic           done_n, aborted_n;
  logic           clr_stats, inc_timeout;
  logic           retrig_q;

  // Incoming segment fields
  logic [CW-1:0]  in_on, in_off;
  logic [RW-1:0]  in_rep;
  logic [NCH-1:0] in_mask;
  assign {in_on, in_off, in_rep, in_mask} = seg_data;

  logic [CW:0] period_sum;
  logic        period_end, rep_last, seg_end;
  logic        retrig_rise, timeout, release_w, transfer, high_n;

  // One extra bit so on+off never overflows; a zero-length period is one low cycle.
  assign period_sum  = {1'b0, on_cfg} + {1'b0, off_cfg};
  assign period_end  = (period_sum == '0) ? 1'b1 : (pos == period_sum - PONE);
  assign rep_last    = ((rep_cnt + RONE) == rep_cfg);
  assign seg_end     = (state == GEN) && period_end && rep_last;
  assign retrig_rise = retrig_in && !retrig_q;
  assign timeout     = (on_cfg != '0) && ((pos + PONE) == {1'b0, on_cfg});
  assign release_w   = (state == WAIT) && (retrig_rise || timeout);

  // Abort (any state) and reset both withdraw the ready for this cycle.
  assign seg_ready = !reset && !abort &&
                     (((state == IDLE) && start) || seg_end || release_w);
  assign transfer  = seg_ready && seg_valid;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n     = state;
    pos_n       = pos;
    rep_cnt_n   = rep_cnt;
    on_n        = on_cfg;
    off_n       = off_cfg;
    rep_cfg_n   = rep_cfg;
    mask_n      = mask;
    done_n      = done;
    aborted_n   = aborted;
    clr_stats   = 1'b0;
    inc_timeout = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (seg_valid) begin
            clr_stats = 1'b1;
            done_n    = 1'b0;
            aborted_n = 1'b0;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      GEN: begin
        if (abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (seg_end) begin
          if (!seg_valid) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else if (period_end) begin
          pos_n     = '0;
          rep_cnt_n = rep_cnt + RONE;
        end else begin
          pos_n = pos + PONE;
        end
      end
      WAIT: begin
        if (abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (release_w) begin
          // A coincident trigger wins, so no timeout is recorded.
          inc_timeout = timeout && !retrig_rise;
          if (!seg_valid) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          pos_n = pos + PONE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (transfer) begin
      on_n      = in_on;
      off_n     = in_off;
      rep_cfg_n = in_rep;
      mask_n    = in_mask;
      pos_n     = '0;
      rep_cnt_n = '0;
      state_n   = (in_rep == '0) ? WAIT : GEN;
    end
  end

  // clk_out is registered from next-state values so the first high cycle
  // lands exactly one cycle after acceptance.
  assign high_n = (state_n == GEN) && (pos_n < {1'b0, on_n});

  always_ff @(posedge refclk) begin
    if (reset) begin
      state             <= IDLE;
      pos               <= '0;
      rep_cnt           <= '0;
      on_cfg            <= '0;
      off_cfg           <= '0;
      rep_cfg           <= '0;
      mask              <= '0;
      done              <= 1'b0;
      aborted           <= 1'b0;
      retrig_q          <= 1'b0;
      clk_out           <= INVERT;
      samples_generated <= '0;
      wait_samples      <= '0;
      retrig_timeouts   <= '0;
      segs_accepted     <= '0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      rep_cnt  <= rep_cnt_n;
      on_cfg   <= on_n;
      off_cfg  <= off_n;
      rep_cfg  <= rep_cfg_n;
      mask     <= mask_n;
      done     <= done_n;
      aborted  <= aborted_n;
      retrig_q <= retrig_in;
      clk_out  <= ({NCH{high_n}} & mask_n) ^ INVERT;

      if (clr_stats) begin
        // The start cycle itself accepts the first segment.
        samples_generated <= '0;
        wait_samples      <= '0;
        retrig_timeouts   <= '0;
        segs_accepted     <= 16'd1;
      end else begin
        if (state == GEN)  samples_generated <= samples_generated + 32'd1;
        if (state == WAIT) wait_samples      <= wait_samples + 32'd1;
        if (inc_timeout && (retrig_timeouts != 16'hFFFF))
          retrig_timeouts <= retrig_timeouts + 16'd1;
        if (transfer && (segs_accepted != 16'hFFFF))
          segs_accepted <= segs_accepted + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_segment_clockgen.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_segment_clockgen
// Description : Self-checking bench for multi_segment_clockgen. A behavioural
//               model expands each segment into the expected per-cycle
//               clk_out values, which are queued at start and compared one
//               per cycle. Channel 3 is built inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_segment_clockgen;

  localparam int CW  = 48;
  localparam int RW  = 32;
  localparam int NCH = 4;
  localparam int SW  = 2*CW+RW+NCH;
  localparam logic [NCH-1:0] INV = 4'b1000;

  logic            refclk = 1'b0;
  logic            reset, start, abort, retrig_in, seg_valid, seg_ready;
  logic [SW-1:0]   seg_data;
  logic [NCH-1:0]  clk_out;
  logic            busy, done, aborted;
  logic [31:0]     samples_generated, wait_samples;
  logic [15:0]     retrig_timeouts, segs_accepted;

  multi_segment_clockgen #(.CW(CW), .RW(RW), .NCH(NCH), .INVERT(INV)) dut (
    .refclk(refclk), .reset(reset), .start(start), .abort(abort),
    .retrig_in(retrig_in), .seg_data(seg_data), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .clk_out(clk_out), .busy(busy), .done(done),
    .aborted(aborted), .samples_generated(samples_generated),
    .wait_samples(wait_samples), .retrig_timeouts(retrig_timeouts),
    .segs_accepted(segs_accepted)
  );

  always #5 refclk = ~refclk;

  typedef struct { int on; int off; int rep; logic [3:0] mask; } seg_t;
  typedef struct { seg_t s; int exp_samples; } vec_t;

  seg_t            fifo[$];
  logic [NCH-1:0]  expq[$];
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pack(input seg_t s);
    return {CW'(s.on), CW'(s.off), RW'(s.rep), s.mask};
  endfunction

  task automatic refresh();
    seg_valid = (fifo.size() > 0);
    seg_data  = seg_valid ? pack(fifo[0]) : '0;
  endtask

  // Model: expected clk_out for each GEN cycle of a segment.
  task automatic push_seg(input seg_t s);
    for (int r = 0; r < s.rep; r++) begin
      if (s.on + s.off == 0) expq.push_back(INV);
      for (int k = 0; k < s.on; k++)  expq.push_back(s.mask ^ INV);
      for (int k = 0; k < s.off; k++) expq.push_back(INV);
    end
  endtask

  // One clock: sample handshake, clock, pop source on transfer, score clk_out.
  task automatic cycle();
    logic            xfer;
    logic [NCH-1:0]  e;
    #1;
    xfer = seg_valid && seg_ready;
    @(posedge refclk);
    #1;
    if (xfer) void'(fifo.pop_front());
    refresh();
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("clk_out", clk_out, e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk_out"}, clk_out, INV);
    check({tag, "_seg_ready"}, seg_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_aborted"}, aborted, 1'b0);
    check({tag, "_samples"}, samples_generated, 0);
    check({tag, "_wait"}, wait_samples, 0);
    check({tag, "_timeouts"}, retrig_timeouts, 0);
    check({tag, "_segs"}, segs_accepted, 0);
  endtask

  vec_t tbl[6];
  seg_t sa, sb;

  initial begin
    // Table: single-segment runs; exp_samples = max(on+off,1)*repeat.
    tbl[0] = '{s: '{on: 2, off: 3, rep: 2, mask: 4'b0001}, exp_samples: 10};
    tbl[1] = '{s: '{on: 1, off: 1, rep: 3, mask: 4'b0011}, exp_samples: 6};
    tbl[2] = '{s: '{on: 0, off: 0, rep: 2, mask: 4'b1111}, exp_samples: 2};
    tbl[3] = '{s: '{on: 3, off: 0, rep: 1, mask: 4'b0101}, exp_samples: 3};
    tbl[4] = '{s: '{on: 0, off: 2, rep: 2, mask: 4'b1110}, exp_samples: 4};
    tbl[5] = '{s: '{on: 1, off: 2, rep: 1, mask: 4'b0000}, exp_samples: 3};

    reset = 1'b1; start = 1'b0; abort = 1'b0; retrig_in = 1'b0;
    refresh();
    run(2);
    check_reset_vals("por");
    reset = 1'b0;

    // Table-driven GEN segments
    for (int i = 0; i < 6; i++) begin
      fifo.push_back(tbl[i].s);
      refresh();
      push_seg(tbl[i].s);
      expq.push_back(INV);
      start = 1'b1;
      cycle();
      start = 1'b0;
      run(tbl[i].exp_samples);
      check("tbl_drained", expq.size(), 0);
      check("tbl_done", done, 1'b1);
      check("tbl_busy", busy, 1'b0);
      check("tbl_samples", samples_generated, tbl[i].exp_samples);
      check("tbl_segs", segs_accepted, 1);
    end

    // Two queued segments, no gap between them
    sa = '{on: 2, off: 2, rep: 1, mask: 4'b0001};
    sb = '{on: 1, off: 1, rep: 3, mask: 4'b0001};
    fifo.push_back(sa); fifo.push_back(sb); refresh();
    push_seg(sa); push_seg(sb); expq.push_back(INV);
    start = 1'b1; cycle(); start = 1'b0;
    run(10);
    check("b2b_drained", expq.size(), 0);
    check("b2b_segs", segs_accepted, 2);
    check("b2b_samples", samples_generated, 10);
    check("b2b_done", done, 1'b1);

    // WAIT ended by timeout after 5 cycles
    sa = '{on: 5, off: 0, rep: 0, mask: 4'b0001};
    sb = '{on: 1, off: 0, rep: 1, mask: 4'b0001};
    fifo.push_back(sa); fifo.push_back(sb); refresh();
    for (int k = 0; k < 5; k++) expq.push_back(INV);
    push_seg(sb); expq.push_back(INV);
    start = 1'b1; cycle(); start = 1'b0;
    run(6);
    check("to_drained", expq.size(), 0);
    check("to_timeouts", retrig_timeouts, 1);
    check("to_wait", wait_samples, 5);
    check("to_samples", samples_generated, 1);
    check("to_segs", segs_accepted, 2);

    // WAIT released by retrig rising edge in WAIT cycle 2
    fifo.push_back(sa); fifo.push_back(sb); refresh();
    expq.push_back(INV); expq.push_back(INV);
    push_seg(sb); expq.push_back(INV);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    retrig_in = 1'b1;
    cycle();
    retrig_in = 1'b0;
    cycle();
    check("rt_drained", expq.size(), 0);
    check("rt_timeouts", retrig_timeouts, 0);
    check("rt_wait", wait_samples, 2);
    check("rt_done", done, 1'b1);

    // on=0 WAIT never times out; only a trigger releases it
    sa = '{on: 0, off: 0, rep: 0, mask: 4'b0010};
    sb = '{on: 2, off: 0, rep: 1, mask: 4'b0010};
    fifo.push_back(sa); fifo.push_back(sb); refresh();
    for (int k = 0; k < 31; k++) expq.push_back(INV);
    push_seg(sb); expq.push_back(INV);
    start = 1'b1; cycle(); start = 1'b0;
    run(30);
    check("wf_busy", busy, 1'b1);
    retrig_in = 1'b1;
    cycle();
    retrig_in = 1'b0;
    run(2);
    check("wf_drained", expq.size(), 0);
    check("wf_wait", wait_samples, 31);
    check("wf_timeouts", retrig_timeouts, 0);

    // Abort in the last GEN cycle with another segment waiting
    sa = '{on: 1, off: 1, rep: 1, mask: 4'b0001};
    fifo.push_back(sa); fifo.push_back(sa); refresh();
    expq.push_back(4'b0001 ^ INV); expq.push_back(INV);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    abort = 1'b1;
    #1;
    check("ab_seg_ready", seg_ready, 1'b0);
    cycle();
    abort = 1'b0;
    check("ab_clk_out", clk_out, 4'b1000);
    check("ab_aborted", aborted, 1'b1);
    check("ab_done", done, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_segs", segs_accepted, 1);

    // Abort in IDLE suppresses start
    start = 1'b1; abort = 1'b1;
    #1;
    check("ia_seg_ready", seg_ready, 1'b0);
    cycle();
    start = 1'b0; abort = 1'b0;
    check("ia_busy", busy, 1'b0);
    check("ia_segs", segs_accepted, 1);
    fifo.delete(); refresh();

    // Reset mid-GEN together with start
    sa = '{on: 3, off: 3, rep: 4, mask: 4'b0001};
    fifo.push_back(sa); fifo.push_back(sa); refresh();
    expq.push_back(4'b0001 ^ INV); expq.push_back(4'b0001 ^ INV);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    reset = 1'b1; start = 1'b1;
    cycle();
    #1;
    check("rs_seg_ready_held", seg_ready, 1'b0);
    cycle();
    reset = 1'b0; start = 1'b0;
    #1;
    check_reset_vals("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
